// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 encodings of the M-extension ops
//   - FSM state encoding
//   - step counter width (32 steps)
package muldiv_pkg;

  localparam logic [2:0] MDOP_MUL    = 3'd0;
  localparam logic [2:0] MDOP_MULH   = 3'd1;
  localparam logic [2:0] MDOP_MULHSU = 3'd2;
  localparam logic [2:0] MDOP_MULHU  = 3'd3;
  localparam logic [2:0] MDOP_DIV    = 3'd4;
  localparam logic [2:0] MDOP_DIVU   = 3'd5;
  localparam logic [2:0] MDOP_REM    = 3'd6;
  localparam logic [2:0] MDOP_REMU   = 3'd7;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final result selection and sign correction for the mul/div unit.
// Ports:
//   acc      in  raw 64-bit product, or {quotient, remainder} for divides
//   op       in  funct3 of the operation
//   neg_q    in  negate product / quotient
//   neg_r    in  negate remainder
//   result_c out 32-bit architectural result (combinational)
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [2:0]        op,
  input  logic              neg_q,
  input  logic              neg_r,
  output logic [XLEN-1:0]   result_c
);

  localparam int unsigned W2 = 2 * XLEN;

  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  always_comb begin
    prod     = neg_q ? (~acc + W2'(1)) : acc;
    quo      = neg_q ? (~acc[W2-1:XLEN] + XLEN'(1)) : acc[W2-1:XLEN];
    rem      = neg_r ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    result_c = rem;
    case (op)
      MDOP_MUL:                          result_c = prod[XLEN-1:0];
      MDOP_MULH, MDOP_MULHSU, MDOP_MULHU: result_c = prod[W2-1:XLEN];
      MDOP_DIV, MDOP_DIVU:               result_c = quo;
      default:                           result_c = rem;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX. Holds the pipeline via
// muldiv_stall for 33 cycles (1 for divide special cases) and pulses
// muldiv_done with the registered result.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ID_EX_muldiv          ID/EX holds an M-extension op
//   ID_EX_mdop            funct3 of that op
//   ex_op_a, ex_op_b      forwarded rs1/rs2
//   EX_MEM_flush          abort the in-flight op
//   muldiv_stall          combinational stall request
//   muldiv_done           registered one-cycle done pulse
//   muldiv_result         registered result
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ID_EX_muldiv,
  input  logic [2:0]      ID_EX_mdop,
  input  logic [XLEN-1:0] ex_op_a,
  input  logic [XLEN-1:0] ex_op_b,
  input  logic            EX_MEM_flush,
  output logic            muldiv_stall,
  output logic            muldiv_done,
  output logic [XLEN-1:0] muldiv_result
);

  localparam int unsigned W2 = 2 * XLEN;

  muldiv_state_t    state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       op_q, op_n;
  logic [XLEN-1:0]  a_q, a_n, b_q, b_n;
  logic [W2-1:0]    acc_q, acc_n;
  logic             negq_q, negq_n, negr_q, negr_n;
  logic [XLEN-1:0]  result_n;
  logic             done_n;

  // Operand conditioning at start
  logic            sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  assign sgn_a    = (ID_EX_mdop == MDOP_MULH) || (ID_EX_mdop == MDOP_MULHSU) ||
                    (ID_EX_mdop == MDOP_DIV)  || (ID_EX_mdop == MDOP_REM);
  assign sgn_b    = (ID_EX_mdop == MDOP_MULH) || (ID_EX_mdop == MDOP_DIV) ||
                    (ID_EX_mdop == MDOP_REM);
  assign a_neg    = sgn_a && ex_op_a[XLEN-1];
  assign b_neg    = sgn_b && ex_op_b[XLEN-1];
  assign abs_a    = a_neg ? (XLEN'(0) - ex_op_a) : ex_op_a;
  assign abs_b    = b_neg ? (XLEN'(0) - ex_op_b) : ex_op_b;
  assign div_zero = ID_EX_mdop[2] && (ex_op_b == '0);
  assign div_ovf  = ((ID_EX_mdop == MDOP_DIV) || (ID_EX_mdop == MDOP_REM)) &&
                    (ex_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (ex_op_b == '1);

  // One iteration step. Multiply: a_q multiplicand, b_q multiplier shifting
  // right, product shifts right through acc. Divide: a_q dividend shifting
  // out its MSB, acc = {quotient, partial remainder}.
  logic [XLEN:0]   mul_sum, div_trial, div_diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [W2-1:0]   step_acc;
  logic [XLEN-1:0] fix_result;

  assign mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign div_trial = {acc_q[XLEN-1:0], a_q[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign q_bit     = ~div_diff[XLEN];
  assign rem_next  = q_bit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
  assign step_acc  = op_q[2] ? {acc_q[W2-2:XLEN], q_bit, rem_next}
                             : {mul_sum, acc_q[XLEN-1:1]};

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .acc      (step_acc),
    .op       (op_q),
    .neg_q    (negq_q),
    .neg_r    (negr_q),
    .result_c (fix_result)
  );

  assign muldiv_stall = !EX_MEM_flush &&
                        (((state_q == IDLE) && ID_EX_muldiv) || (state_q == BUSY));

  // Next-state and datapath next values
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    acc_n    = acc_q;
    negq_n   = negq_q;
    negr_n   = negr_q;
    result_n = muldiv_result;
    case (state_q)
      IDLE: begin
        if (ID_EX_muldiv) begin
          op_n   = ID_EX_mdop;
          a_n    = abs_a;
          b_n    = abs_b;
          negq_n = a_neg ^ b_neg;
          negr_n = a_neg;
          acc_n  = '0;
          cnt_n  = '0;
          if (div_zero) begin
            result_n = ID_EX_mdop[1] ? ex_op_a : '1;
            state_n  = DONE;
          end else if (div_ovf) begin
            result_n = ID_EX_mdop[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_n  = DONE;
          end else begin
            state_n  = BUSY;
          end
        end
      end
      BUSY: begin
        acc_n = step_acc;
        cnt_n = cnt_q + CNT_W'(1);
        if (op_q[2]) a_n = {a_q[XLEN-2:0], 1'b0};
        else         b_n = {1'b0, b_q[XLEN-1:1]};
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_n = fix_result;
          state_n  = DONE;
        end
      end
      // DONE never restarts: the held instruction must advance first
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (EX_MEM_flush) begin
      state_n  = IDLE;
      result_n = muldiv_result;
    end
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      negq_q        <= 1'b0;
      negr_q        <= 1'b0;
      muldiv_result <= '0;
      muldiv_done   <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      op_q          <= op_n;
      a_q           <= a_n;
      b_q           <= b_n;
      acc_q         <= acc_n;
      negq_q        <= negq_n;
      negr_q        <= negr_n;
      muldiv_result <= result_n;
      muldiv_done   <= done_n;
    end
  end

endmodule
